// File: rtl/insn_decoder_pkg.sv
// insn_decoder_pkg: shared instruction widths, field positions and opcode constants.
package insn_decoder_pkg;
    localparam int LEN_INSN = 32;
    localparam int LEN_OPC  = 6;
    localparam int LEN_REG  = 5;
    localparam int LEN_IMM  = 32;
    localparam int OPC_HI = 31, OPC_LO = 26;
    localparam int RD_HI  = 25, RD_LO  = 21;
    localparam int RS_HI  = 20, RS_LO  = 16;
    localparam int RT_HI  = 15, RT_LO  = 11;
    localparam int IMM_HI = 15, IMM_LO = 0;
    localparam logic [LEN_OPC-1:0] OPC_NOP  = 6'h00;
    localparam logic [LEN_OPC-1:0] OPC_ALU  = 6'h01;
    localparam logic [LEN_OPC-1:0] OPC_ALUI = 6'h02;
    localparam logic [LEN_OPC-1:0] OPC_LD   = 6'h03;
    localparam logic [LEN_OPC-1:0] OPC_ST   = 6'h04;
    localparam logic [LEN_OPC-1:0] OPC_BR   = 6'h05;
    localparam logic [LEN_OPC-1:0] OPC_LIMM = 6'h06;
    localparam logic [LEN_OPC-1:0] OPC_HALT = 6'h3F;
endpackage

// File: rtl/insn_field_decode.sv
// insn_field_decode: combinational opcode-to-class-flags and immediate extension.
// INSN_DECODER_ILLEGAL_TRAP_EN enables the unknown-opcode flag; otherwise illegal is tied low.
module insn_field_decode
    import insn_decoder_pkg::*;
(
    input  logic [LEN_OPC-1:0] opc,
    input  logic [15:0]        imm16,
    output logic               is_alu,
    output logic               is_ld,
    output logic               is_st,
    output logic               is_br,
    output logic               is_halt,
    output logic               illegal,
    output logic [LEN_IMM-1:0] imm
);
    logic sext;
    always_comb begin
        is_alu  = (opc == OPC_ALU) || (opc == OPC_ALUI);
        is_ld   = opc == OPC_LD;
        is_st   = opc == OPC_ST;
        is_br   = opc == OPC_BR;
        is_halt = opc == OPC_HALT;
        sext    = opc inside {OPC_ALUI, OPC_LD, OPC_ST, OPC_BR};
        imm     = sext ? {{(LEN_IMM-16){imm16[15]}}, imm16} : '0;
    end
`ifdef INSN_DECODER_ILLEGAL_TRAP_EN
    assign illegal = !(opc inside {OPC_NOP, OPC_ALU, OPC_ALUI, OPC_LD, OPC_ST,
                                   OPC_BR, OPC_LIMM, OPC_HALT});
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: rtl/insn_decoder.sv
// insn_decoder: registered decode stage that merges LIMM prefix + extension word into one op.
// Optional INSN_DECODER_ILLEGAL_TRAP_EN flags unknown opcodes via illegal_o.
module insn_decoder
    import insn_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic [LEN_INSN-1:0] insn_i,
    output logic                stall_o,
    output logic                valid_o,
    input  logic                stall_i,
    output logic [LEN_OPC-1:0]  opc_o,
    output logic [LEN_REG-1:0]  rd_o,
    output logic [LEN_REG-1:0]  rs_o,
    output logic [LEN_REG-1:0]  rt_o,
    output logic [LEN_IMM-1:0]  imm_o,
    output logic                is_alu_o,
    output logic                is_ld_o,
    output logic                is_st_o,
    output logic                is_br_o,
    output logic                is_halt_o,
    output logic                illegal_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXT  = 1'b1;

    logic [0:0]         state;
    logic [LEN_REG-1:0] hold_rd;
    logic [15:0]        hold_lo;
    logic               d_alu, d_ld, d_st, d_br, d_halt, d_ill;
    logic [LEN_IMM-1:0] d_imm;
    logic [LEN_OPC-1:0] opc;

    assign opc     = insn_i[OPC_HI:OPC_LO];
    assign stall_o = stall_i & valid_o;

    insn_field_decode u_dec (
        .opc     (opc),
        .imm16   (insn_i[IMM_HI:IMM_LO]),
        .is_alu  (d_alu),
        .is_ld   (d_ld),
        .is_st   (d_st),
        .is_br   (d_br),
        .is_halt (d_halt),
        .illegal (d_ill),
        .imm     (d_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_rd   <= '0;
            hold_lo   <= '0;
            valid_o   <= 1'b0;
            opc_o     <= '0;
            rd_o      <= '0;
            rs_o      <= '0;
            rt_o      <= '0;
            imm_o     <= '0;
            is_alu_o  <= 1'b0;
            is_ld_o   <= 1'b0;
            is_st_o   <= 1'b0;
            is_br_o   <= 1'b0;
            is_halt_o <= 1'b0;
            illegal_o <= 1'b0;
        end else if (!stall_i && !valid_i) begin
            valid_o <= 1'b0;
        end else if (!stall_i && state == ST_EXT) begin
            // extension word: its own opcode is ignored, only the high half matters
            state     <= ST_IDLE;
            valid_o   <= 1'b1;
            opc_o     <= OPC_LIMM;
            rd_o      <= hold_rd;
            rs_o      <= '0;
            rt_o      <= '0;
            imm_o     <= {insn_i[IMM_HI:IMM_LO], hold_lo};
            is_alu_o  <= 1'b0;
            is_ld_o   <= 1'b0;
            is_st_o   <= 1'b0;
            is_br_o   <= 1'b0;
            is_halt_o <= 1'b0;
            illegal_o <= 1'b0;
        end else if (!stall_i && opc == OPC_LIMM) begin
            state   <= ST_EXT;
            hold_rd <= insn_i[RD_HI:RD_LO];
            hold_lo <= insn_i[IMM_HI:IMM_LO];
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o   <= 1'b1;
            opc_o     <= opc;
            rd_o      <= insn_i[RD_HI:RD_LO];
            rs_o      <= insn_i[RS_HI:RS_LO];
            rt_o      <= insn_i[RT_HI:RT_LO];
            imm_o     <= d_imm;
            is_alu_o  <= d_alu;
            is_ld_o   <= d_ld;
            is_st_o   <= d_st;
            is_br_o   <= d_br;
            is_halt_o <= d_halt;
            illegal_o <= d_ill;
        end
    end
endmodule

// File: tb/tb_insn_decoder.sv
// tb_insn_decoder: directed vectors checked against a word-level behavioural model plus literal pins.
module tb_insn_decoder;
`ifdef INSN_DECODER_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, valid_i, stall_i;
    logic [31:0] insn_i;
    logic        stall_o, valid_o, is_alu_o, is_ld_o, is_st_o, is_br_o, is_halt_o, illegal_o;
    logic [5:0]  opc_o;
    logic [4:0]  rd_o, rs_o, rt_o;
    logic [31:0] imm_o;

    int checks = 0;
    int errors = 0;
    bit live = 1'b0;

    insn_decoder dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .insn_i(insn_i), .stall_o(stall_o),
        .valid_o(valid_o), .stall_i(stall_i), .opc_o(opc_o), .rd_o(rd_o), .rs_o(rs_o),
        .rt_o(rt_o), .imm_o(imm_o), .is_alu_o(is_alu_o), .is_ld_o(is_ld_o), .is_st_o(is_st_o),
        .is_br_o(is_br_o), .is_halt_o(is_halt_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // model state: expected outputs and a pending-prefix memory
    logic        m_valid = 1'b0, m_pend = 1'b0, m_ill = 1'b0;
    logic [5:0]  m_opc = '0;
    logic [4:0]  m_rd = '0, m_rs = '0, m_rt = '0, m_hrd = '0;
    logic [15:0] m_hlo = '0;
    logic [31:0] m_imm = '0;
    logic [4:0]  m_flags = '0;

    function automatic logic [4:0] flags_of(input logic [5:0] op);
        case (op)
            6'h01, 6'h02: return 5'b10000;
            6'h03:        return 5'b01000;
            6'h04:        return 5'b00100;
            6'h05:        return 5'b00010;
            6'h3F:        return 5'b00001;
            default:      return 5'b00000;
        endcase
    endfunction

    function automatic bit known(input logic [5:0] op);
        return op <= 6'h06 || op == 6'h3F;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 0; m_pend <= 0; m_opc <= 0; m_rd <= 0; m_rs <= 0; m_rt <= 0;
            m_imm <= 0; m_flags <= 0; m_ill <= 0;
        end else if (!stall_i) begin
            if (!valid_i) m_valid <= 0;
            else if (m_pend) begin
                m_pend <= 0; m_valid <= 1; m_opc <= 6'h06; m_rd <= m_hrd; m_rs <= 0; m_rt <= 0;
                m_imm <= insn_i[15:0] * 32'h10000 + m_hlo; m_flags <= 0; m_ill <= 0;
            end else if (insn_i[31:26] == 6'h06) begin
                m_pend <= 1; m_valid <= 0; m_hrd <= insn_i[25:21]; m_hlo <= insn_i[15:0];
            end else begin
                m_valid <= 1; m_opc <= insn_i[31:26]; m_rd <= insn_i[25:21];
                m_rs <= insn_i[20:16]; m_rt <= insn_i[15:11];
                m_imm <= (insn_i[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05})
                         ? 32'($signed({1'b0, insn_i[15:0]}) - (insn_i[15] ? 32'sh10000 : 0)) : 0;
                m_flags <= flags_of(insn_i[31:26]);
                m_ill <= TRAP && !known(insn_i[31:26]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (live) begin
        chk("valid_o", valid_o, m_valid);
        chk("stall_o", stall_o, stall_i & m_valid);
        if (m_valid) begin
            chk("opc_o", opc_o, m_opc);
            chk("rd_o", rd_o, m_rd);
            chk("imm_o", imm_o, m_imm);
            chk("flags", {is_alu_o, is_ld_o, is_st_o, is_br_o, is_halt_o}, m_flags);
            chk("illegal_o", illegal_o, m_ill);
            if (m_opc != 6'h06) begin
                chk("rs_o", rs_o, m_rs);
                chk("rt_o", rt_o, m_rt);
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic s, input logic [31:0] w);
        rst = r; valid_i = v; stall_i = s; insn_i = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; valid_i = 0; stall_i = 0; insn_i = 0;
        cyc(1, 0, 0, 0);
        live = 1;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("lit_reset_valid", valid_o, 0);
        chk("lit_reset_stall", stall_o, 0);
        chk("lit_reset_fields", {opc_o, rd_o, rs_o, rt_o}, 0);
        chk("lit_reset_imm", imm_o, 0);
        // ALUI rd=3 rs=4 imm=0xFFF0
        cyc(0, 1, 0, {6'h02, 5'd3, 5'd4, 16'hFFF0});
        chk("lit_alui_valid", valid_o, 1);
        chk("lit_alui_opc", opc_o, 6'h02);
        chk("lit_alui_rd_rs", {rd_o, rs_o}, {5'd3, 5'd4});
        chk("lit_alui_imm", imm_o, 32'hFFFF_FFF0);
        chk("lit_alui_alu", is_alu_o, 1);
        // LIMM pair
        cyc(0, 1, 0, {6'h06, 5'd7, 5'd0, 16'h5678});
        chk("lit_limm_bubble", valid_o, 0);
        cyc(0, 1, 0, 32'h0000_1234);
        chk("lit_limm_valid", valid_o, 1);
        chk("lit_limm_rd", rd_o, 7);
        chk("lit_limm_imm", imm_o, 32'h1234_5678);
        // stall hold on LD
        cyc(0, 1, 0, {6'h03, 5'd1, 5'd2, 16'h8000});
        chk("lit_ld_imm", imm_o, 32'hFFFF_8000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, {6'h04, 5'd8, 5'd9, 16'h0010});
            chk("lit_stall_opc", opc_o, 6'h03);
            chk("lit_stall_o", stall_o, 1);
        end
        cyc(0, 1, 0, {6'h04, 5'd8, 5'd9, 16'h0010});
        chk("lit_after_stall_opc", opc_o, 6'h04);
        chk("lit_after_stall_st", is_st_o, 1);
        // LIMM with bubbles; ext opcode HALT must be ignored
        cyc(0, 1, 0, {6'h06, 5'd9, 5'd0, 16'hBEEF});
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 32'hFC00_CAFE);
        chk("lit_bubble_imm", imm_o, 32'hCAFE_BEEF);
        chk("lit_bubble_halt", is_halt_o, 0);
        // reset inside a pair
        cyc(0, 1, 0, {6'h06, 5'd2, 5'd0, 16'h1111});
        cyc(1, 0, 0, 0);
        chk("lit_midreset_valid", valid_o, 0);
        cyc(0, 1, 0, {6'h01, 5'd5, 5'd6, 5'd7, 11'd0});
        chk("lit_midreset_opc", opc_o, 6'h01);
        chk("lit_midreset_alu", is_alu_o, 1);
        // back-to-back pairs, stall while in EXT, other classes
        cyc(0, 1, 0, {6'h06, 5'd1, 5'd0, 16'h0001});
        cyc(0, 1, 0, 32'h0000_0002);
        cyc(0, 1, 0, {6'h06, 5'd3, 5'd0, 16'hFFFF});
        cyc(0, 1, 1, 32'h1234_8000);
        cyc(0, 1, 0, 32'h1234_8000);
        chk("lit_b2b_imm", imm_o, 32'h8000_FFFF);
        cyc(0, 1, 0, {6'h05, 5'd0, 5'd0, 16'h7FFF});
        cyc(0, 1, 0, {6'h3F, 26'd0});
        cyc(0, 1, 0, {6'h00, 5'd4, 5'd4, 16'hFFFF});
        cyc(0, 1, 0, {6'h20, 5'd6, 5'd1, 16'hFFFF});
        chk("lit_unknown_valid", valid_o, 1);
        chk("lit_unknown_ill", illegal_o, TRAP);
        chk("lit_unknown_flags", {is_alu_o, is_ld_o, is_st_o, is_br_o, is_halt_o}, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
